// File: rtl/mm_row_accumulator_pkg.sv
// Shared constants, FSM state encoding and fp32 constants for the row accumulator.
package mm_row_accumulator_pkg;
   localparam int DW      = 32;
   localparam int DEPTH   = 64;
   localparam int AW      = 6;
   localparam int ADD_LAT = 11;

   localparam logic [DW-1:0] FP_ZERO = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      DRAIN  = 2'd2,
      OUTPUT = 2'd3
   } state_t;
endpackage

// File: rtl/floating_point_add.sv
// Stand-in for the vendor fp32 adder: free-running pipeline of LAT stages,
// round-to-nearest-even, denormals flushed, no reset (matches the IP).
module floating_point_add #(
   parameter int LAT = 11
) (
   input  logic        aclk,
   input  logic        s_axis_a_tvalid,
   input  logic [31:0] s_axis_a_tdata,
   input  logic        s_axis_b_tvalid,
   input  logic [31:0] s_axis_b_tdata,
   output logic        m_axis_result_tvalid,
   output logic [31:0] m_axis_result_tdata
);
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [7:0]  d;
      logic [26:0] mx, my;
      logic [27:0] s;
      logic [24:0] r;
      logic        sticky, rnd;
      int          e, lz;
      if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? {a[31] & b[31], 31'd0} : b;
      if (b[30:23] == 8'd0) return a;
      if (a[30:0] >= b[30:0]) begin x = a; y = b; end
      else begin x = b; y = a; end
      d  = x[30:23] - y[30:23];
      mx = {1'b1, x[22:0], 3'b000};
      my = {1'b1, y[22:0], 3'b000};
      if (d > 8'd26) my = 27'd1;
      else begin
         sticky = |(my & ((27'd1 << d) - 27'd1));
         my     = (my >> d) | {26'd0, sticky};
      end
      e = {24'd0, x[30:23]};
      if (x[31] == y[31]) begin
         s = {1'b0, mx} + {1'b0, my};
         if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 1;
         end
      end else begin
         s = {1'b0, mx} - {1'b0, my};
         if (s == 28'd0) return 32'h0000_0000;
         lz = 0;
         for (int i = 0; i < 27; i++) if (s[i]) lz = 26 - i;
         s = s << lz;
         e = e - lz;
      end
      rnd = s[2] & (s[1] | s[0] | s[3]);
      r   = {1'b0, s[26:3]} + {24'd0, rnd};
      if (r[24]) begin
         r = r >> 1;
         e = e + 1;
      end
      if (e >= 255) return {x[31], 8'hFF, 23'd0};
      if (e <= 0)   return {x[31], 31'd0};
      return {x[31], e[7:0], r[22:0]};
   endfunction

   logic [31:0]    sum_p [LAT];
   logic [LAT-1:0] vld_p;

   always_ff @(posedge aclk) begin
      sum_p[0] <= fp_add(s_axis_a_tdata, s_axis_b_tdata);
      for (int i = 1; i < LAT; i++) sum_p[i] <= sum_p[i-1];
      vld_p <= {vld_p[LAT-2:0], s_axis_a_tvalid & s_axis_b_tvalid};
   end

   assign m_axis_result_tdata  = sum_p[LAT-1];
   assign m_axis_result_tvalid = vld_p[LAT-1];
endmodule

// File: rtl/mm_acc_ram.sv
// Row buffer: one write port, an async read port for accumulation and a
// registered read port for streaming results out.
module mm_acc_ram #(
   parameter int DW    = 32,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr_a,
   output logic [DW-1:0] rdata_a,
   input  logic          re_b,
   input  logic [AW-1:0] raddr_b,
   output logic [DW-1:0] rdata_b
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (re_b) rdata_b <= mem[raddr_b];
   end

   assign rdata_a = mem[raddr_a];
endmodule

// File: rtl/mm_row_accumulator.sv
// Accumulates chunk-major fp32 partial sums per row into an on-chip buffer,
// then streams the finished rows out under valid/ready.
module mm_row_accumulator
   import mm_row_accumulator_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW:0]   cfg_rows,
   input  logic [15:0]   cfg_chunks,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic          err
);
   localparam int DRW = $clog2(ADD_LAT + 1);

   state_t          state;
   logic [AW:0]     rows_q;
   logic [15:0]     chunks_q;
   logic [AW-1:0]   row;
   logic [15:0]     chunk;
   logic [DRW-1:0]  drain_cnt;
   logic [AW:0]     rd_addr;
   logic [AW-1:0]   tag_row_p [ADD_LAT];
   logic [ADD_LAT-1:0] tag_vld_p;
   logic [DW-1:0]   ram_rd_a, ram_rd_b, add_b, add_res;
   logic            add_vld, acc_fire, cfg_ok, rd_issue, out_fire, wr_en;

   assign acc_fire = in_valid && (state == ACCUM);
   assign cfg_ok   = (cfg_rows >= (AW+1)'(ADD_LAT + 1)) && (cfg_rows <= (AW+1)'(DEPTH))
                     && (cfg_chunks != 16'd0);
   assign add_b    = (chunk == 16'd0) ? FP_ZERO : ram_rd_a;
   assign wr_en    = tag_vld_p[ADD_LAT-1] && add_vld;
   assign rd_issue = (state == OUTPUT) && (!out_valid || out_ready) && (rd_addr != rows_q);
   assign out_fire = out_valid && out_ready;
   assign out_data = out_valid ? ram_rd_b : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         rows_q    <= '0;
         chunks_q  <= '0;
         row       <= '0;
         chunk     <= '0;
         drain_cnt <= '0;
         rd_addr   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= in_valid && (state != ACCUM);
         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     rows_q   <= cfg_rows;
                     chunks_q <= cfg_chunks;
                     row      <= '0;
                     chunk    <= '0;
                     busy     <= 1'b1;
                     state    <= ACCUM;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  if ({1'b0, row} == rows_q - (AW+1)'(1)) begin
                     row <= '0;
                     if (chunk == chunks_q - 16'd1) begin
                        chunk     <= '0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                     end else begin
                        chunk <= chunk + 16'd1;
                     end
                  end else begin
                     row <= row + AW'(1);
                  end
               end
            end
            DRAIN: begin
               // Waits out the adder pipeline so the last writeback is readable.
               if (drain_cnt == DRW'(ADD_LAT)) begin
                  drain_cnt <= '0;
                  rd_addr   <= '0;
                  state     <= OUTPUT;
               end else begin
                  drain_cnt <= drain_cnt + DRW'(1);
               end
            end
            OUTPUT: begin
               if (rd_issue) begin
                  rd_addr   <= rd_addr + (AW+1)'(1);
                  out_valid <= 1'b1;
                  out_last  <= (rd_addr == rows_q - (AW+1)'(1));
               end else if (out_fire) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end
               if (out_fire && out_last) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Row tag travels alongside the adder pipeline; valids reset so in-flight sums die.
   always_ff @(posedge clk) begin
      if (!rst_n) tag_vld_p <= '0;
      else        tag_vld_p <= {tag_vld_p[ADD_LAT-2:0], acc_fire};
   end

   always_ff @(posedge clk) begin
      tag_row_p[0] <= row;
      for (int i = 1; i < ADD_LAT; i++) tag_row_p[i] <= tag_row_p[i-1];
   end

   floating_point_add #(.LAT(ADD_LAT)) u_add (
      .aclk                 (clk),
      .s_axis_a_tvalid      (acc_fire),
      .s_axis_a_tdata       (in_data),
      .s_axis_b_tvalid      (acc_fire),
      .s_axis_b_tdata       (add_b),
      .m_axis_result_tvalid (add_vld),
      .m_axis_result_tdata  (add_res)
   );

   mm_acc_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .we      (wr_en),
      .waddr   (tag_row_p[ADD_LAT-1]),
      .wdata   (add_res),
      .raddr_a (row),
      .rdata_a (ram_rd_a),
      .re_b    (rd_issue),
      .raddr_b (rd_addr[AW-1:0]),
      .rdata_b (ram_rd_b)
   );
endmodule

// File: tb/tb_mm_row_accumulator.sv
// Bench for mm_row_accumulator: integer-valued partials summed exactly in a
// scoreboard, converted to fp32 and compared beat by beat on the output stream.
module tb_mm_row_accumulator;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [6:0]  cfg_rows = '0;
   logic [15:0] cfg_chunks = '0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_last;
   logic        busy, done, err;

   int n_chk = 0;
   int n_pass = 0;
   int rdy_mode = 0;
   logic [32:0] exp_q[$];

   mm_row_accumulator dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows),
      .cfg_chunks(cfg_chunks), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] int_to_fp(input int v);
      logic [31:0] m;
      int p;
      if (v == 0) return 32'h0;
      m = (v < 0) ? -v : v;
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      m = m << (23 - p);
      return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + p), m[22:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clk) begin : compare
      logic        stall_prev;
      logic [31:0] prev_data;
      logic        prev_last;
      logic [32:0] e;
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, prev_data);
            check("stall_last", out_last, prev_last);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL extra_beat: got %h expected no beat", out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_data", out_data, e[31:0]);
               check("out_last", out_last, e[32]);
            end
         end
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   // mode 0: row r = r+1, 1: all ones, 2: chunk0 r / others -r, 3: random with gaps
   task automatic run_job(input int rows, input int chunks, input int mode, input int rmode,
                          input int rst_c, input int rst_r);
      int acc[64];
      int v;
      int k;
      foreach (acc[i]) acc[i] = 0;
      rdy_mode   = rmode;
      cfg_rows   = 7'(rows);
      cfg_chunks = 16'(chunks);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1);
      for (int c = 0; c < chunks; c++) begin
         for (int r = 0; r < rows; r++) begin
            if (c == rst_c && r == rst_r) begin
               rst_n = 1'b0;
               tick();
               tick();
               rst_n = 1'b1;
               check("busy_after_rst", busy, 0);
               check("valid_after_rst", out_valid, 0);
               return;
            end
            if (mode == 3) repeat ($urandom_range(0, 2)) tick();
            case (mode)
               0:       v = r + 1;
               1:       v = 1;
               2:       v = (c == 0) ? r : -r;
               default: v = int'($urandom_range(0, 1000)) - 500;
            endcase
            acc[r] += v;
            in_data  = int_to_fp(v);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
         end
      end
      for (int r = 0; r < rows; r++) exp_q.push_back({(r == rows - 1) ? 1'b1 : 1'b0, int_to_fp(acc[r])});
      k = 0;
      while (k < 3000 && !done) begin
         tick();
         k++;
      end
      if (!done) begin
         n_chk++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", k);
         exp_q.delete();
      end else begin
         check("queue_drained", exp_q.size(), 0);
         check("busy_at_done", busy, 0);
         tick();
         check("done_pulse_end", done, 0);
      end
   endtask

   initial begin
      int bad_rows[3];
      int bad_chunks[3];
      bad_rows   = '{5, 65, 12};
      bad_chunks = '{1, 1, 0};
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      rst_n = 1'b1;
      tick();

      check("pin_fp_1", int_to_fp(1), 32'h3F80_0000);
      check("pin_fp_3", int_to_fp(3), 32'h4040_0000);
      check("pin_fp_12", int_to_fp(12), 32'h4140_0000);
      check("pin_fp_m2", int_to_fp(-2), 32'hC000_0000);

      run_job(12, 1, 0, 0, -1, -1);
      run_job(16, 3, 1, 0, -1, -1);
      run_job(12, 2, 2, 1, -1, -1);

      for (int i = 0; i < 3; i++) begin
         cfg_rows   = 7'(bad_rows[i]);
         cfg_chunks = 16'(bad_chunks[i]);
         start = 1'b1;
         tick();
         start = 1'b0;
         check("bad_cfg_err", err, 1);
         check("bad_cfg_busy", busy, 0);
         tick();
         check("bad_cfg_err_end", err, 0);
      end

      in_data  = int_to_fp(99);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("idle_in_err", err, 1);
      tick();
      check("idle_in_err_end", err, 0);
      run_job(12, 1, 0, 0, -1, -1);

      run_job(12, 3, 3, 0, 1, 4);
      run_job(12, 1, 3, 2, -1, -1);
      run_job(64, 2, 3, 2, -1, -1);
      run_job(12, 4, 3, 1, -1, -1);
      repeat (3) run_job(int'($urandom_range(12, 64)), int'($urandom_range(1, 3)), 3, 2, -1, -1);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
